// File: rtl/shared_pkg.sv
// Shared constants, count-width helper and status bundle for fifo_param_sync and its bench.
package shared_pkg;

   localparam int DEF_FIFO_WIDTH = 16;
   localparam int DEF_FIFO_DEPTH = 8;

   // Width able to hold every occupancy value 0..depth inclusive.
   function automatic int cnt_width(input int depth);
      return $clog2(depth + 1);
   endfunction

   typedef struct packed {
      logic full;
      logic empty;
      logic almostfull;
      logic almostempty;
      logic overflow;
      logic underflow;
   } fifo_status_t;

endpackage

// File: rtl/fifo_mem_2p.sv
// Simple dual-port register array: synchronous write, asynchronous read, no reset.
module fifo_mem_2p #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 8,
   parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_param_sync.sv
// Parametrised single-clock FIFO with margins, occupancy, high-water mark and sticky errors.
// Define FIFO_FWFT_EN for first-word-fall-through output; default is 1-cycle registered read.
module fifo_param_sync
   import shared_pkg::*;
#(
   parameter int FIFO_WIDTH = DEF_FIFO_WIDTH,
   parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
   parameter int AF_MARGIN  = 1,
   parameter int AE_MARGIN  = 1,
   localparam int CW        = cnt_width(FIFO_DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [FIFO_WIDTH-1:0] data_in,
   input  logic                  wr_en,
   input  logic                  rd_en,
   input  logic                  clr_err,
   output logic [FIFO_WIDTH-1:0] data_out,
   output logic                  wr_ack,
   output logic                  overflow,
   output logic                  underflow,
   output logic                  full,
   output logic                  empty,
   output logic                  almostfull,
   output logic                  almostempty,
   output logic [CW-1:0]         count,
   output logic [CW-1:0]         hwm,
   output logic                  err_ovf_sticky,
   output logic                  err_udf_sticky
);

   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
   localparam logic [CW-1:0] AF_LVL  = CW'(FIFO_DEPTH - AF_MARGIN);
   localparam logic [CW-1:0] AE_LVL  = CW'(AE_MARGIN);
   localparam logic [PW-1:0] LAST    = PW'(FIFO_DEPTH - 1);

   logic [PW-1:0]         wr_ptr, rd_ptr;
   logic [CW-1:0]         count_nxt;
   logic [FIFO_WIDTH-1:0] rdata;
   logic                  wr_acc, rd_acc, ovf_nxt, udf_nxt;
   fifo_status_t          status;

   always_comb begin
      status             = '0;
      status.full        = (count == DEPTH_C);
      status.empty       = (count == '0);
      status.almostfull  = !status.full  && (count >= AF_LVL);
      status.almostempty = !status.empty && (count <= AE_LVL);
      status.overflow    = overflow;
      status.underflow   = underflow;
   end

   assign full        = status.full;
   assign empty       = status.empty;
   assign almostfull  = status.almostfull;
   assign almostempty = status.almostempty;

   // A full FIFO still takes a write when a read frees the head slot on the same edge.
   // An empty FIFO never serves a read, even with a concurrent write, in either build.
   assign wr_acc  = wr_en && (!status.full || rd_en);
   assign rd_acc  = rd_en && !status.empty;
   assign ovf_nxt = wr_en && status.full && !rd_en;
   assign udf_nxt = rd_en && status.empty;

   always_comb begin
      count_nxt = count;
      unique case ({wr_acc, rd_acc})
         2'b10:   count_nxt = count + 1'b1;
         2'b01:   count_nxt = count - 1'b1;
         default: count_nxt = count;
      endcase
   end

   fifo_mem_2p #(.WIDTH(FIFO_WIDTH), .DEPTH(FIFO_DEPTH), .AW(PW)) u_mem (
      .clk   (clk),
      .we    (wr_acc),
      .waddr (wr_ptr),
      .wdata (data_in),
      .raddr (rd_ptr),
      .rdata (rdata)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         count          <= '0;
         hwm            <= '0;
         wr_ack         <= 1'b0;
         overflow       <= 1'b0;
         underflow      <= 1'b0;
         err_ovf_sticky <= 1'b0;
         err_udf_sticky <= 1'b0;
      end else begin
         if (wr_acc) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
         if (rd_acc) rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
         count          <= count_nxt;
         hwm            <= (clr_err || count_nxt > hwm) ? count_nxt : hwm;
         wr_ack         <= wr_acc;
         overflow       <= ovf_nxt;
         underflow      <= udf_nxt;
         // A fresh error on the clearing edge keeps the bit set.
         err_ovf_sticky <= ovf_nxt || (err_ovf_sticky && !clr_err);
         err_udf_sticky <= udf_nxt || (err_udf_sticky && !clr_err);
      end
   end

`ifdef FIFO_FWFT_EN
   // Head is re-registered every cycle the FIFO holds data, so it lags the head pointer by one cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)             data_out <= '0;
      else if (!status.empty) data_out <= rdata;
   end
`else
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      data_out <= '0;
      else if (rd_acc) data_out <= rdata;
   end
`endif

endmodule

// File: tb/tb_fifo_param_sync.sv
// Directed self-checking bench for fifo_param_sync (16x8, margins 1); FWFT sequence under FIFO_FWFT_EN.
module tb_fifo_param_sync;
   import shared_pkg::*;

   localparam int W  = 16;
   localparam int D  = 8;
   localparam int CW = cnt_width(D);

   logic          clk = 1'b0;
   logic          rst_n;
   logic [W-1:0]  data_in;
   logic          wr_en, rd_en, clr_err;
   logic [W-1:0]  data_out;
   logic          wr_ack, overflow, underflow;
   logic          full, empty, almostfull, almostempty;
   logic [CW-1:0] count, hwm;
   logic          err_ovf_sticky, err_udf_sticky;

   int checks = 0;
   int errors = 0;

   fifo_param_sync #(.FIFO_WIDTH(W), .FIFO_DEPTH(D), .AF_MARGIN(1), .AE_MARGIN(1)) dut (
      .clk(clk), .rst_n(rst_n), .data_in(data_in), .wr_en(wr_en), .rd_en(rd_en),
      .clr_err(clr_err), .data_out(data_out), .wr_ack(wr_ack), .overflow(overflow),
      .underflow(underflow), .full(full), .empty(empty), .almostfull(almostfull),
      .almostempty(almostempty), .count(count), .hwm(hwm),
      .err_ovf_sticky(err_ovf_sticky), .err_udf_sticky(err_udf_sticky)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // Drive one cycle of stimulus, then sample 1 time unit after the edge.
   task automatic step(input logic wr, input logic rd, input logic [W-1:0] d);
      wr_en   = wr;
      rd_en   = rd;
      data_in = d;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] stat(input logic f, input logic e, input logic af,
                                        input logic ae, input logic o, input logic u);
      fifo_status_t s;
      s = '{full: f, empty: e, almostfull: af, almostempty: ae, overflow: o, underflow: u};
      return 32'(s);
   endfunction

   function automatic logic [31:0] dut_stat();
      return stat(full, empty, almostfull, almostempty, overflow, underflow);
   endfunction

   initial begin
      rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0; data_in = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_count", 32'(count), 0);
      chk("rst_stat", dut_stat(), stat(0, 1, 0, 0, 0, 0));
      chk("rst_dout", 32'(data_out), 0);
      chk("rst_hwm", 32'(hwm), 0);
      rst_n = 1'b1;

`ifdef FIFO_FWFT_EN
      step(1, 0, 16'h5A5A);
      chk("fw_cnt1", 32'(count), 1);
      chk("fw_dout_pre", 32'(data_out), 0);
      step(0, 0, '0);
      chk("fw_dout", 32'(data_out), 32'h5A5A);
      chk("fw_nempty", 32'(empty), 0);
      step(0, 1, '0);
      chk("fw_empty", 32'(empty), 1);
      chk("fw_cnt0", 32'(count), 0);
      step(1, 1, 16'h1234);
      chk("fw_udf", 32'(underflow), 1);
      chk("fw_udf_cnt", 32'(count), 1);
      step(0, 0, '0);
      chk("fw_dout2", 32'(data_out), 32'h1234);
      chk("fw_sticky", 32'(err_udf_sticky), 1);
`else
      // Reset mid-fill discards everything.
      for (int i = 0; i < 5; i++) step(1, 0, W'(16'h0100 + i));
      chk("mid_count", 32'(count), 5);
      wr_en = 1'b0;
      rst_n = 1'b0;
      #2;
      chk("mid_rst_count", 32'(count), 0);
      chk("mid_rst_stat", dut_stat(), stat(0, 1, 0, 0, 0, 0));
      chk("mid_rst_dout", 32'(data_out), 0);
      chk("mid_rst_hwm", 32'(hwm), 0);
      chk("mid_rst_ack", 32'(wr_ack), 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Fill 1..8 with flag checks at the boundaries.
      for (int i = 1; i <= 8; i++) begin
         step(1, 0, W'(i));
         chk($sformatf("fill_ack%0d", i), 32'(wr_ack), 1);
         chk($sformatf("fill_cnt%0d", i), 32'(count), 32'(i));
         if (i == 1) chk("fill_ae1", dut_stat(), stat(0, 0, 0, 1, 0, 0));
         if (i == 7) chk("fill_af7", dut_stat(), stat(0, 0, 1, 0, 0, 0));
         if (i == 8) chk("fill_full8", dut_stat(), stat(1, 0, 0, 0, 0, 0));
      end
      step(1, 0, 16'h0009);
      chk("ovf_flag", 32'(overflow), 1);
      chk("ovf_ack", 32'(wr_ack), 0);
      chk("ovf_sticky", 32'(err_ovf_sticky), 1);
      chk("ovf_cnt", 32'(count), 8);
      step(0, 0, '0);
      chk("ovf_clear", 32'(overflow), 0);
      chk("ovf_hold", 32'(err_ovf_sticky), 1);
      chk("hwm8", 32'(hwm), 8);

      // Drain with 1-cycle read latency.
      for (int i = 1; i <= 8; i++) begin
         step(0, 1, '0);
         chk($sformatf("drain_d%0d", i), 32'(data_out), 32'(i));
         chk($sformatf("drain_cnt%0d", i), 32'(count), 32'(8 - i));
         if (i == 7) chk("drain_ae", dut_stat(), stat(0, 0, 0, 1, 0, 0));
      end
      step(0, 1, '0);
      chk("udf_flag", 32'(underflow), 1);
      chk("udf_sticky", 32'(err_udf_sticky), 1);
      chk("udf_dout_hold", 32'(data_out), 8);
      chk("udf_cnt", 32'(count), 0);

      // Empty with simultaneous read and write: only the write lands.
      step(1, 1, 16'h0777);
      chk("ewr_udf", 32'(underflow), 1);
      chk("ewr_ack", 32'(wr_ack), 1);
      chk("ewr_cnt", 32'(count), 1);
      chk("ewr_dout", 32'(data_out), 8);
      step(0, 1, '0);
      chk("ewr_rd", 32'(data_out), 32'h0777);
      chk("ewr_cnt0", 32'(count), 0);

      // Full with simultaneous read and write.
      for (int i = 0; i < 8; i++) step(1, 0, W'(16'h0A00 + i));
      chk("refill_full", 32'(full), 1);
      step(1, 1, 16'hABCD);
      chk("fsim_ovf", 32'(overflow), 0);
      chk("fsim_ack", 32'(wr_ack), 1);
      chk("fsim_cnt", 32'(count), 8);
      chk("fsim_dout", 32'(data_out), 32'h0A00);
      for (int i = 1; i <= 8; i++) begin
         step(0, 1, '0);
         chk($sformatf("fsim_d%0d", i), 32'(data_out), (i == 8) ? 32'hABCD : 32'(16'h0A00 + i));
      end
      chk("fsim_empty", 32'(empty), 1);

      // Clear errors and high-water mark with FIFO empty.
      clr_err = 1'b1;
      step(0, 0, '0);
      clr_err = 1'b0;
      chk("clr_hwm0", 32'(hwm), 0);
      chk("clr_ovf", 32'(err_ovf_sticky), 0);
      chk("clr_udf", 32'(err_udf_sticky), 0);

      // Wrap-around: occupancy alternates 3 <-> 4 across pointer wrap.
      begin
         int wv, rv;
         wv = 16'h2000;
         rv = 16'h2000;
         for (int i = 0; i < 3; i++) begin
            step(1, 0, W'(wv));
            wv++;
         end
         for (int i = 0; i < 10; i++) begin
            step(1, 0, W'(wv));
            wv++;
            chk($sformatf("wrap_cw%0d", i), 32'(count), 4);
            step(0, 1, '0);
            chk($sformatf("wrap_d%0d", i), 32'(data_out), 32'(rv));
            chk($sformatf("wrap_cr%0d", i), 32'(count), 3);
            rv++;
         end
      end
      chk("wrap_hwm", 32'(hwm), 4);
      chk("wrap_sticky", {30'd0, err_ovf_sticky, err_udf_sticky}, 0);
      clr_err = 1'b1;
      step(0, 0, '0);
      clr_err = 1'b0;
      chk("clr_hwm3", 32'(hwm), 3);

      // New error on the clearing edge wins over the clear.
      clr_err = 1'b1;
      for (int i = 0; i < 5; i++) step(1, 0, W'(16'h3000 + i));
      step(1, 0, 16'h3FFF);
      clr_err = 1'b0;
      chk("clr_vs_ovf", 32'(err_ovf_sticky), 1);
      chk("clr_vs_ovf_hwm", 32'(hwm), 8);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1);
   end

endmodule
